egress_reader: RTL and testbench
================================

Name: egress_reader

Overview:
- Host-facing read side of the packet switch. Accepts switched words from the three output ports (strobe plus 32-bit word per port).
- Buffers them in per-port circular queues.
- Lets the HPS drain them over the same Avalon-MM slave conventions the ingress path uses for writes: chipselect, read/write, 4-bit word address, 32-bit data.
- Also exposes occupancy, sticky error flags and drop counters.

Parameters:
- DEPTH, 16: words per port queue; power of two, 2..128.
- PTR_W, 4: log2(DEPTH); queue pointer width. Count width is PTR_W+1.
- ID_WORD, 32'h5357_4F52: constant returned at address 0.

Ports:
- clk  in  1  system clock (50 MHz domain).
- reset  in  1  synchronous, active-low reset; 0 = reset, sampled on posedge clk.
- out_ram_wr1  in  1  port-1 egress word strobe, one word per high cycle.
- out_ram_wr2  in  1  port-2 egress word strobe.
- out_ram_wr3  in  1  port-3 egress word strobe.
- output1  in  32  port-1 egress word, valid with out_ram_wr1.
- output2  in  32  port-2 egress word.
- output3  in  32  port-3 egress word.
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  4  Avalon word address.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data.
- data_avail  out  3  bit i-1 high when port i queue is non-empty (level, usable as IRQ source).

Behaviour:
- Reset (reset==0 at posedge clk):
  - All pointers, counts, drop counters and sticky flags go to 0. readdata=0, data_avail=0.
  - Queue contents are discarded, including mid-packet; no partial state survives.
  - Egress strobes and bus accesses in a reset cycle are ignored.
- Enqueue: on posedge with out_ram_wrN=1:
  - Not full (count<DEPTH): write outputN at wr_ptr, wr_ptr+1 mod DEPTH, count+1.
  - Full: word dropped; overflow flag N set (sticky); dropN increments, saturating at 16'hFFFF.
- Read access (chipselect&&read), one-cycle read latency: readdata is registered and valid the cycle after the strobe. The host issues one-cycle read pulses; each high cycle is one access.
  - addr 0: ID_WORD.
  - addr 1/2/3, pop port N:
    - Non-empty: readdata = head word; rd_ptr+1 mod DEPTH; count-1.
    - Empty: readdata = 0; pointers unchanged; underflow flag N set (sticky).
  - addr 4 status, non-destructive:
    - [7:0] count1, [15:8] count2, [23:16] count3, zero-extended.
    - [26:24] underflow flags 3..1.
    - [29:27] overflow flags 3..1.
    - [31:30] 0.
  - addr 5: {16'b0, drop1}. addr 6: {16'b0, drop2}. addr 7: {16'b0, drop3}.
  - other addresses: readdata = 0, no side effect.
- Simultaneous enqueue and pop on the same port in one cycle:
  - Both take effect; count unchanged.
  - On an empty queue the pop returns 0 and sets underflow. There is no bypass; the word is stored.
  - On a full queue the enqueue succeeds because the pop frees a slot; no drop.
- Write access (chipselect&&write):
  - addr 15, writedata[0]=1: clear all sticky flags and drop counters. An overflow occurring in the same cycle wins: its flag ends set and its counter ends at 1.
  - addr 15, writedata[1]=1: flush all queues (pointers/counts to 0).
  - All other addresses: no effect.
  - Simultaneous read and write: both are processed independently.
- readdata holds its last value when there is no read access.
- data_avail[N-1] = (countN != 0), registered from the same state as count; updates the cycle after the enqueue/pop.
- Wrap-around: pointers wrap modulo DEPTH; FIFO order is preserved across the wrap.
- Storage: one 32×DEPTH array per port, inferred as registers or MLAB. No combinational path from address to readdata.

Test Plan:
- Reset (reset=0, 3 cycles) → readdata=0, data_avail=3'b000, addr4 reads 0x00000000; addr0 reads 0x53574F52.
- Strobe output1=0xA0..0xA4 (5 words), then 5 pops at addr1 → readdata 0xA0..0xA4 in order, each one cycle after its pop; addr4[7:0]=0 and data_avail[0]=0 afterwards.
- Write 17 words to port 2 (DEPTH=16) → addr4[15:8]=16, addr4[28]=1, addr6=1; pops return the first 16 words and the 17th is absent; write addr15 data 1 → addr4[28]=0, addr6=0.
- Pop addr3 on an empty queue → readdata=0, addr4[26]=1, count3 stays 0.
- Full port 1 plus same-cycle enqueue 0xBEEF and pop → pop returns the oldest word, count stays 16, addr5=0; draining 16 words ends with 0xBEEF.
- 40 enqueue/pop pairs on port 1 with DEPTH=16 (pointer wrap) → all words returned in order; assert reset mid-stream → all counts 0, following pops return 0 with underflow set.

Source files
------------

// File: rtl/egress_reader.sv
// Host read side of the packet switch: three egress word streams are buffered in
// per-port circular queues and drained over an Avalon-MM slave with one-cycle read latency.
module egress_reader #(
    parameter int          DEPTH   = 16,
    parameter int          PTR_W   = 4,
    parameter logic [31:0] ID_WORD = 32'h5357_4F52
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        out_ram_wr1,
    input  logic        out_ram_wr2,
    input  logic        out_ram_wr3,
    input  logic [31:0] output1,
    input  logic [31:0] output2,
    input  logic [31:0] output3,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [2:0]  data_avail
);

    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    logic [2:0]  push_req;
    logic [95:0] push_data;
    logic        rd_acc;
    logic        wr_acc;
    logic        clear_req;
    logic        flush_req;

    assign push_req  = {out_ram_wr3, out_ram_wr2, out_ram_wr1};
    assign push_data = {output3, output2, output1};
    assign rd_acc    = chipselect && read;
    assign wr_acc    = chipselect && write;
    assign clear_req = wr_acc && (address == 4'hF) && writedata[0];
    assign flush_req = wr_acc && (address == 4'hF) && writedata[1];

    logic [95:0] head_w;
    logic [23:0] cnt8_w;
    logic [47:0] drop_w;
    logic [2:0]  udf_w;
    logic [2:0]  ovf_w;
    logic [2:0]  avail_w;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_port
            logic [31:0]      mem_q [DEPTH];
            logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [15:0]      drop_q, drop_d;
            logic             udf_q, udf_d;
            logic             ovf_q, ovf_d;
            logic             avail_q;
            logic             pop_req, pop_ok, push_ok, overflow;

            assign pop_req  = rd_acc && (address == 4'(gi + 1));
            assign pop_ok   = pop_req && (cnt_q != '0);
            // A same-cycle pop frees the slot, so a full queue still accepts the word.
            assign push_ok  = push_req[gi] && ((cnt_q != FULL_CNT) || pop_ok);
            assign overflow = push_req[gi] && !push_ok;

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                udf_d    = udf_q;
                ovf_d    = ovf_q;
                drop_d   = drop_q;
                if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_ONE;
                else if (pop_ok && !push_ok) cnt_d = cnt_q - CNT_ONE;
                if (flush_req) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                end
                if (clear_req) begin
                    udf_d  = 1'b0;
                    ovf_d  = 1'b0;
                    drop_d = '0;
                end
                // Events in the clearing cycle are applied after the clear so they survive.
                if (pop_req && !pop_ok) udf_d = 1'b1;
                if (overflow) begin
                    ovf_d = 1'b1;
                    if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                    drop_q   <= '0;
                    udf_q    <= 1'b0;
                    ovf_q    <= 1'b0;
                    avail_q  <= 1'b0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                    drop_q   <= drop_d;
                    udf_q    <= udf_d;
                    ovf_q    <= ovf_d;
                    avail_q  <= (cnt_d != '0);
                end
            end

            always_ff @(posedge clk) begin
                if (reset && push_ok) mem_q[wr_ptr_q] <= push_data[gi*32 +: 32];
            end

            assign head_w[gi*32 +: 32] = mem_q[rd_ptr_q];
            assign cnt8_w[gi*8 +: 8]   = 8'(cnt_q);
            assign drop_w[gi*16 +: 16] = drop_q;
            assign udf_w[gi]           = udf_q;
            assign ovf_w[gi]           = ovf_q;
            assign avail_w[gi]         = avail_q;
        end
    endgenerate

    logic [31:0] readdata_d;
    logic [31:0] readdata_q;

    always_comb begin
        readdata_d = '0;
        case (address)
            4'd0: readdata_d = ID_WORD;
            4'd1: readdata_d = (cnt8_w[7:0]   != 8'd0) ? head_w[31:0]  : 32'd0;
            4'd2: readdata_d = (cnt8_w[15:8]  != 8'd0) ? head_w[63:32] : 32'd0;
            4'd3: readdata_d = (cnt8_w[23:16] != 8'd0) ? head_w[95:64] : 32'd0;
            4'd4: readdata_d = {2'b00, ovf_w, udf_w, cnt8_w};
            4'd5: readdata_d = {16'd0, drop_w[15:0]};
            4'd6: readdata_d = {16'd0, drop_w[31:16]};
            4'd7: readdata_d = {16'd0, drop_w[47:32]};
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)      readdata_q <= '0;
        else if (rd_acc) readdata_q <= readdata_d;
    end

    assign readdata   = readdata_q;
    assign data_avail = avail_w;

endmodule

// File: tb/tb_egress_reader.sv
// Directed and randomized checks of egress_reader against a queue-based model of the
// three port buffers, flags, drop counters and the registered read data.
module tb_egress_reader;

    localparam int          DEPTH = 16;
    localparam logic [31:0] ID    = 32'h5357_4F52;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_ram_wr1, out_ram_wr2, out_ram_wr3;
    logic [31:0] output1, output2, output3;
    logic        chipselect, read, write;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [2:0]  data_avail;

    always #5 clk = ~clk;

    egress_reader #(.DEPTH(DEPTH), .PTR_W(4), .ID_WORD(ID)) dut (
        .clk(clk), .reset(reset),
        .out_ram_wr1(out_ram_wr1), .out_ram_wr2(out_ram_wr2), .out_ram_wr3(out_ram_wr3),
        .output1(output1), .output2(output2), .output3(output3),
        .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata),
        .readdata(readdata), .data_avail(data_avail)
    );

    // Reference model
    logic [31:0] mq [3][$];
    bit          m_udf [3];
    bit          m_ovf [3];
    int          m_drop [3];
    logic [31:0] m_rd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [2:0] m_avail();
        logic [2:0] a;
        for (int p = 0; p < 3; p++) a[p] = (mq[p].size() != 0);
        return a;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        for (int p = 0; p < 3; p++) begin
            s[p*8 +: 8] = 8'(mq[p].size());
            s[24 + p]   = m_udf[p];
            s[27 + p]   = m_ovf[p];
        end
        return s;
    endfunction

    task automatic model_step(input logic rst_n, input logic [2:0] wr, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input logic rd_en,
                              input logic wr_en, input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] words [3];
        int          a;
        words = '{w1, w2, w3};
        a = int'(addr);
        if (!rst_n) begin
            for (int p = 0; p < 3; p++) begin
                mq[p].delete();
                m_udf[p] = 0;
                m_ovf[p] = 0;
                m_drop[p] = 0;
            end
            m_rd = '0;
            return;
        end
        if (rd_en) begin
            if (a == 0) m_rd = ID;
            else if (a >= 1 && a <= 3) m_rd = (mq[a-1].size() > 0) ? mq[a-1][0] : 32'd0;
            else if (a == 4) m_rd = m_status();
            else if (a >= 5 && a <= 7) m_rd = 32'(m_drop[a-5]);
            else m_rd = '0;
        end
        if (wr_en && a == 15 && wd[0]) begin
            for (int p = 0; p < 3; p++) begin
                m_udf[p] = 0;
                m_ovf[p] = 0;
                m_drop[p] = 0;
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (rd_en && a == p + 1) begin
                if (mq[p].size() > 0) void'(mq[p].pop_front());
                else m_udf[p] = 1;
            end
            if (wr[p]) begin
                if (mq[p].size() < DEPTH) mq[p].push_back(words[p]);
                else begin
                    m_ovf[p] = 1;
                    if (m_drop[p] < 65535) m_drop[p]++;
                end
            end
        end
        if (wr_en && a == 15 && wd[1])
            for (int p = 0; p < 3; p++) mq[p].delete();
    endtask

    task automatic cycle(input logic [2:0] wr, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic rd_en, input logic wr_en,
                         input logic [3:0] addr, input logic [31:0] wd);
        {out_ram_wr3, out_ram_wr2, out_ram_wr1} = wr;
        output1 = w1; output2 = w2; output3 = w3;
        chipselect = rd_en | wr_en; read = rd_en; write = wr_en;
        address = addr; writedata = wd;
        @(posedge clk);
        model_step(reset, wr, w1, w2, w3, rd_en, wr_en, addr, wd);
        #1;
        if (rd_en && reset) $display("rd addr=%0d data=0x%08h", addr, readdata);
        chk("readdata", readdata, m_rd);
        chk("data_avail", {29'd0, data_avail}, {29'd0, m_avail()});
        {out_ram_wr3, out_ram_wr2, out_ram_wr1} = 3'b000;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic idle();
        cycle(3'b000, 0, 0, 0, 1'b0, 1'b0, 4'd0, 0);
    endtask

    task automatic rd(input logic [3:0] addr);
        cycle(3'b000, 0, 0, 0, 1'b1, 1'b0, addr, 0);
    endtask

    task automatic push(input int p, input logic [31:0] w);
        cycle(3'(1 << p), w, w, w, 1'b0, 1'b0, 4'd0, 0);
    endtask

    task automatic wr15(input logic [31:0] wd);
        cycle(3'b000, 0, 0, 0, 1'b0, 1'b1, 4'hF, wd);
    endtask

    initial begin
        logic [31:0] w [40];
        logic [31:0] r;
        logic [3:0]  ra;

        reset = 1'b0;
        {out_ram_wr3, out_ram_wr2, out_ram_wr1} = 3'b000;
        output1 = '0; output2 = '0; output3 = '0;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        m_rd = '0;

        // Reset
        repeat (3) idle();
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_avail", {29'd0, data_avail}, 32'd0);
        reset = 1'b1;
        rd(4'd4); chk("rst_status", readdata, 32'd0);
        rd(4'd0); chk("id_word", readdata, 32'h5357_4F52);

        // Basic FIFO order on port 1
        for (int i = 0; i < 5; i++) push(0, 32'hA0 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            rd(4'd1); chk("pop1_order", readdata, 32'hA0 + 32'(i));
        end
        rd(4'd4); chk("cnt1_empty", {24'd0, readdata[7:0]}, 32'd0);
        chk("avail1_low", {31'd0, data_avail[0]}, 32'd0);

        // Overflow on port 2
        for (int i = 0; i < 17; i++) begin
            w[i] = $urandom;
            push(1, w[i]);
        end
        rd(4'd4);
        chk("cnt2_full", {24'd0, readdata[15:8]}, 32'd16);
        chk("ovf2_set", {31'd0, readdata[28]}, 32'd1);
        rd(4'd6); chk("drop2_one", readdata, 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd(4'd2); chk("pop2_order", readdata, w[i]);
        end
        rd(4'd2); chk("pop2_17th_absent", readdata, 32'd0);
        wr15(32'd1);
        rd(4'd4); chk("ovf2_cleared", {31'd0, readdata[28]}, 32'd0);
        rd(4'd6); chk("drop2_cleared", readdata, 32'd0);

        // Underflow on port 3
        rd(4'd3); chk("pop3_empty", readdata, 32'd0);
        rd(4'd4);
        chk("udf3_set", {31'd0, readdata[26]}, 32'd1);
        chk("cnt3_zero", {24'd0, readdata[23:16]}, 32'd0);

        // Full port 1 with simultaneous enqueue and pop
        for (int i = 0; i < 16; i++) begin
            w[i] = $urandom;
            push(0, w[i]);
        end
        cycle(3'b001, 32'h0000_BEEF, 0, 0, 1'b1, 1'b0, 4'd1, 0);
        chk("full_pop_oldest", readdata, w[0]);
        rd(4'd4); chk("full_cnt_kept", {24'd0, readdata[7:0]}, 32'd16);
        rd(4'd5); chk("full_no_drop", readdata, 32'd0);
        for (int i = 1; i < 16; i++) begin
            rd(4'd1); chk("full_drain", readdata, w[i]);
        end
        rd(4'd1); chk("drain_last_beef", readdata, 32'h0000_BEEF);

        // Pointer wrap with 40 enqueue/pop pairs
        for (int i = 0; i < 40; i++) begin
            w[i] = $urandom;
            push(0, w[i]);
            rd(4'd1); chk("wrap_order", readdata, w[i]);
        end

        // Reset mid-stream
        for (int i = 0; i < 3; i++) push(0, $urandom);
        push(1, $urandom);
        reset = 1'b0;
        idle();
        reset = 1'b1;
        rd(4'd4); chk("midrst_counts", {8'd0, readdata[23:0]}, 32'd0);
        rd(4'd1); chk("midrst_pop", readdata, 32'd0);
        rd(4'd4); chk("midrst_udf1", {31'd0, readdata[24]}, 32'd1);

        // Randomized traffic on all ports, checked every cycle by the model
        for (int i = 0; i < 400; i++) begin
            r  = $urandom;
            ra = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 39) == 0)
                cycle(3'(r), $urandom, $urandom, $urandom, r[3], 1'b1, 4'hF, {30'd0, r[5:4]});
            else
                cycle(3'(r), $urandom, $urandom, $urandom, r[3] | r[6], 1'b0, ra, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
